dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Arbiter that shares the single-port data memory between the pipeline MEM stage (CPU port) and a secondary block-transfer master (DMA port, used by the loader/console). Each cycle it selects one requester and steers its address, write data, write enable and size/extension selects onto the memory. It returns read data to the winner and stalls the pipeline when the CPU loses. CPU has default priority. Bounded DMA bursts and a starvation counter guarantee progress for both sides.

## Interface
- MAX_BURST, 4: max consecutive locked DMA grants while CpuReq is high (1..15).
- STARVE_LIMIT, 8: denied DMA cycles after which DMA is forced through (1..15).
- Clk  in  1  system clock; all state changes on posedge.
- Reset  in  1  asynchronous, active-high reset.
- CpuReq  in  1  MEM stage needs memory this cycle.
- CpuWE  in  1  CPU store.
- CpuAddr  in  32  CPU byte address.
- CpuWD  in  32  CPU store data.
- CpuSizeSel  in  `WIDTH_DMSIZESEL  CPU word/half/byte select.
- CpuExtSel  in  `WIDTH_DMEXTSEL  CPU sign/unsign select.
- CpuRD  out  32  memory read data, combinational passthrough.
- CpuStall  out  1  CPU request denied this cycle; pipeline must hold.
- DmaReq  in  1  DMA request; held until granted.
- DmaLock  in  1  DMA requests back-to-back grants (burst).
- DmaWE, DmaAddr, DmaWD, DmaSizeSel, DmaExtSel  in  1/32/32/`WIDTH_DMSIZESEL/`WIDTH_DMEXTSEL  DMA request fields.
- DmaGnt  out  1  DMA request accepted this cycle.
- DmaRD  out  32  registered read data.
- DmaRDValid  out  1  DmaRD valid; one-cycle pulse.
- DMWE  out  1  to memory write enable.
- DMAddr, DMWD  out  32  to memory.
- DMSizeSel, DMExtSel  out  `WIDTH_DMSIZESEL/`WIDTH_DMEXTSEL  to memory.
- DMRD  in  32  memory combinational read data.

## Operation
- State registers:
  - Owner ∈ {NONE, CPU, DMA}: last granted requester.
  - BurstCnt[3:0]
  - WaitCnt[3:0]
  - DmaRD, DmaRDValid
- Grant is combinational from the inputs and registered state, evaluated in this order:
  - Reset high: no grant.
  - Only one request: that requester wins.
  - Both request and WaitCnt == STARVE_LIMIT: DMA wins.
  - Both request, Owner == DMA, DmaLock = 1 and BurstCnt < MAX_BURST: DMA wins.
  - Otherwise: CPU wins.
- Mux: DM* outputs come from the winner. With no grant, DMWE = 0 and the remaining DM* outputs are 0.
- CpuStall = CpuReq & !cpu_grant. DmaGnt = dma_grant.
- CpuRD = DMRD at all times; it is meaningful only when the CPU is granted.
- Owner update each posedge: set to the winner; NONE if no grant.
- BurstCnt:
  - DMA granted with CpuReq = 1: increment, saturating at MAX_BURST.
  - Any other cycle: clear to 0.
- WaitCnt:
  - DmaReq & !DmaGnt: increment, saturating at STARVE_LIMIT.
  - Otherwise: clear to 0.
- DMA read: on a DMA grant with DmaWE = 0, DMRD is registered into DmaRD and DmaRDValid = 1 next cycle. Otherwise DmaRDValid = 0 and DmaRD holds.
- Write hazard: a DMA store and a CPU load to the same word are serialized by grant order. The store takes effect at the granting posedge, so a CPU load granted later sees the new data.

## Timing
- Reset values:
  - Owner = NONE, BurstCnt = 0, WaitCnt = 0, DmaRD = 0, DmaRDValid = 0.
  - While Reset is high: DMWE = 0, CpuStall = 0, DmaGnt = 0.
- Grant and stall latency: 0 cycles (same cycle as the request).
- Write latency: the store commits at the posedge ending the grant cycle.
- DMA read latency: DmaRDValid one cycle after DmaGnt.
- CPU read latency: 0 (same cycle).
- DMA must hold DmaReq and all DMA fields stable until DmaGnt. Deasserting the request before grant is legal and clears WaitCnt.
- Bound on consecutive CPU denials: MAX_BURST + 1 cycles. This covers a locked burst plus one starvation grant; starvation cannot fire back-to-back because WaitCnt clears on grant.
- Bound on consecutive DMA denials: STARVE_LIMIT cycles, then a guaranteed grant.
- Asynchronous reset mid-burst: state clears immediately. An in-flight DmaRDValid is dropped, and the DMA must reissue.
- Simultaneous same-cycle requests with Owner == NONE: CPU wins.

## Test plan
- Reset held, both requesting with CpuWE = DmaWE = 1 → DMWE = 0, CpuStall = 0, DmaGnt = 0. Release reset → CPU granted, DMWE follows CpuWE.
- CPU idle; DMA reads word at 0x10 holding 0xDEADBEEF → DmaGnt same cycle, DmaRDValid = 1 with DmaRD = 0xDEADBEEF next cycle.
- DMA granted alone, then CpuReq rises with DmaLock = 1, MAX_BURST = 4 → DMA granted 4 more cycles with CpuStall = 1, then CPU granted (stall drops).
- CpuReq held high continuously, DmaReq high, DmaLock = 0, STARVE_LIMIT = 8 → DMA denied cycles 0–7, granted cycle 8 (one cycle CpuStall), then CPU again.
- DMA byte store 0xAA to 0x23 granted, CPU word load of 0x20 next cycle → CpuRD[31:24] = 0xAA, other bytes unchanged.
- Assert Reset asynchronously between clock edges during a locked DMA burst → DmaGnt drops immediately, counters 0, no DmaRDValid pulse after release.

Source files
------------

// File: rtl/dm_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and the DMA master.
// CPU has default priority; bounded DMA bursts and a starvation counter guarantee progress.
module dm_arbiter #(
    parameter int MAX_BURST    = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int SIZE_W       = 2,
    parameter int EXT_W        = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_wd_i,
    input  logic [SIZE_W-1:0] cpu_size_sel_i,
    input  logic [EXT_W-1:0]  cpu_ext_sel_i,
    output logic [31:0]       cpu_rd_o,
    output logic              cpu_stall_o,
    input  logic              dma_req_i,
    input  logic              dma_lock_i,
    input  logic              dma_we_i,
    input  logic [31:0]       dma_addr_i,
    input  logic [31:0]       dma_wd_i,
    input  logic [SIZE_W-1:0] dma_size_sel_i,
    input  logic [EXT_W-1:0]  dma_ext_sel_i,
    output logic              dma_gnt_o,
    output logic [31:0]       dma_rd_o,
    output logic              dma_rd_valid_o,
    output logic              dm_we_o,
    output logic [31:0]       dm_addr_o,
    output logic [31:0]       dm_wd_o,
    output logic [SIZE_W-1:0] dm_size_sel_o,
    output logic [EXT_W-1:0]  dm_ext_sel_o,
    input  logic [31:0]       dm_rd_i
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);
    localparam logic [3:0] WAIT_MAX  = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    owner_e      owner_q, owner_d;
    logic [3:0]  burst_q, burst_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] dma_rd_q, dma_rd_d;
    logic        dma_rd_valid_q, dma_rd_valid_d;
    logic        cpu_gnt, dma_gnt;

    // DMA wins when alone, when starved, or while continuing a locked burst
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!rst_i) begin
            if (dma_req_i && (!cpu_req_i || wait_q == WAIT_MAX ||
                              (owner_q == OWN_DMA && dma_lock_i && burst_q < BURST_MAX))) begin
                dma_gnt = 1'b1;
            end else if (cpu_req_i) begin
                cpu_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        dm_we_o       = 1'b0;
        dm_addr_o     = '0;
        dm_wd_o       = '0;
        dm_size_sel_o = '0;
        dm_ext_sel_o  = '0;
        if (dma_gnt) begin
            dm_we_o       = dma_we_i;
            dm_addr_o     = dma_addr_i;
            dm_wd_o       = dma_wd_i;
            dm_size_sel_o = dma_size_sel_i;
            dm_ext_sel_o  = dma_ext_sel_i;
        end else if (cpu_gnt) begin
            dm_we_o       = cpu_we_i;
            dm_addr_o     = cpu_addr_i;
            dm_wd_o       = cpu_wd_i;
            dm_size_sel_o = cpu_size_sel_i;
            dm_ext_sel_o  = cpu_ext_sel_i;
        end
    end

    always_comb begin
        owner_d        = dma_gnt ? OWN_DMA : (cpu_gnt ? OWN_CPU : OWN_NONE);
        burst_d        = '0;
        wait_d         = '0;
        dma_rd_d       = dma_rd_q;
        dma_rd_valid_d = 1'b0;
        if (dma_gnt && cpu_req_i) begin
            burst_d = (burst_q >= BURST_MAX) ? BURST_MAX : burst_q + 4'd1;
        end
        if (dma_req_i && !dma_gnt) begin
            wait_d = (wait_q >= WAIT_MAX) ? WAIT_MAX : wait_q + 4'd1;
        end
        if (dma_gnt && !dma_we_i) begin
            dma_rd_d       = dm_rd_i;
            dma_rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q        <= OWN_NONE;
            burst_q        <= '0;
            wait_q         <= '0;
            dma_rd_q       <= '0;
            dma_rd_valid_q <= 1'b0;
        end else begin
            owner_q        <= owner_d;
            burst_q        <= burst_d;
            wait_q         <= wait_d;
            dma_rd_q       <= dma_rd_d;
            dma_rd_valid_q <= dma_rd_valid_d;
        end
    end

    assign cpu_rd_o       = dm_rd_i;
    assign cpu_stall_o    = !rst_i && cpu_req_i && !cpu_gnt;
    assign dma_gnt_o      = dma_gnt;
    assign dma_rd_o       = dma_rd_q;
    assign dma_rd_valid_o = dma_rd_valid_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios, then randomized traffic against a rule-level model
// with a byte-lane memory (size 0 = word, 1 = half, 2 = byte, little-endian lanes).
module tb_dm_arbiter;
    localparam int MB = 4;
    localparam int SL = 8;

    logic        clk, rst;
    logic        cpu_req, cpu_we, cpu_ext, cpu_stall;
    logic [31:0] cpu_addr, cpu_wd, cpu_rd;
    logic [1:0]  cpu_sz;
    logic        dma_req, dma_lock, dma_we, dma_ext, dma_gnt, dma_rdv;
    logic [31:0] dma_addr, dma_wd, dma_rd;
    logic [1:0]  dma_sz;
    logic        dm_we;
    logic [31:0] dm_addr, dm_wd, dm_rd;
    logic [1:0]  dm_sz;
    logic        dm_ext;

    logic [31:0] mem [0:63];
    assign dm_rd = mem[dm_addr[7:2]];

    int n_cmp = 0, n_err = 0;
    int m_owner, m_burst, m_wait, last_w, cpu_den, dma_den;
    logic [31:0] m_rd;
    logic        m_rdv;

    dm_arbiter #(.MAX_BURST(MB), .STARVE_LIMIT(SL), .SIZE_W(2), .EXT_W(1)) dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wd_i(cpu_wd),
        .cpu_size_sel_i(cpu_sz), .cpu_ext_sel_i(cpu_ext), .cpu_rd_o(cpu_rd), .cpu_stall_o(cpu_stall),
        .dma_req_i(dma_req), .dma_lock_i(dma_lock), .dma_we_i(dma_we), .dma_addr_i(dma_addr),
        .dma_wd_i(dma_wd), .dma_size_sel_i(dma_sz), .dma_ext_sel_i(dma_ext), .dma_gnt_o(dma_gnt),
        .dma_rd_o(dma_rd), .dma_rd_valid_o(dma_rdv),
        .dm_we_o(dm_we), .dm_addr_o(dm_addr), .dm_wd_o(dm_wd), .dm_size_sel_o(dm_sz),
        .dm_ext_sel_o(dm_ext), .dm_rd_i(dm_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // 0 = no grant, 1 = CPU, 2 = DMA
    function automatic int exp_winner();
        if (rst) return 0;
        if (!cpu_req && !dma_req) return 0;
        if (cpu_req && !dma_req) return 1;
        if (dma_req && !cpu_req) return 2;
        if (m_wait == SL) return 2;
        if (m_owner == 2 && dma_lock && m_burst < MB) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] rand_addr(logic [1:0] sz);
        logic [31:0] a;
        a = 32'($urandom_range(0, 255));
        if (sz == 2'd0) a[1:0] = 2'b00;
        if (sz == 2'd1) a[0] = 1'b0;
        return a;
    endfunction

    task automatic model_reset();
        m_owner = 0; m_burst = 0; m_wait = 0; m_rd = '0; m_rdv = 1'b0;
        cpu_den = 0; dma_den = 0;
    endtask

    // Check one cycle mid-period, advance the model and memory, then step to posedge+1.
    task automatic cycle();
        int w;
        logic e_we, e_ext;
        logic [31:0] e_addr, e_wd;
        logic [1:0] e_sz;
        logic [5:0] idx;
        #2;
        w = exp_winner();
        e_we = 1'b0; e_ext = 1'b0; e_addr = '0; e_wd = '0; e_sz = '0;
        if (w == 1) begin
            e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wd; e_sz = cpu_sz; e_ext = cpu_ext;
        end else if (w == 2) begin
            e_we = dma_we; e_addr = dma_addr; e_wd = dma_wd; e_sz = dma_sz; e_ext = dma_ext;
        end
        chk("dma_gnt", 32'(dma_gnt), 32'(w == 2));
        chk("cpu_stall", 32'(cpu_stall), 32'(!rst && cpu_req && w != 1));
        chk("dm_we", 32'(dm_we), 32'(e_we));
        chk("dm_addr", dm_addr, e_addr);
        chk("dm_wd", dm_wd, e_wd);
        chk("dm_size", 32'(dm_sz), 32'(e_sz));
        chk("dm_ext", 32'(dm_ext), 32'(e_ext));
        chk("dma_rd_valid", 32'(dma_rdv), 32'(m_rdv));
        chk("dma_rd", dma_rd, m_rd);
        if (!rst && cpu_req && w != 1) cpu_den++; else cpu_den = 0;
        if (!rst && dma_req && w != 2) dma_den++; else dma_den = 0;
        chk("cpu_denial_bound", 32'(cpu_den <= MB + 1), 32'd1);
        chk("dma_denial_bound", 32'(dma_den <= SL), 32'd1);
        if (rst) begin
            model_reset();
        end else begin
            if (w == 2 && !dma_we) begin
                m_rd = mem[dma_addr[7:2]];
                m_rdv = 1'b1;
            end else begin
                m_rdv = 1'b0;
            end
            m_burst = (w == 2 && cpu_req) ? ((m_burst + 1 > MB) ? MB : m_burst + 1) : 0;
            m_wait  = (dma_req && w != 2) ? ((m_wait + 1 > SL) ? SL : m_wait + 1) : 0;
            m_owner = w;
            if (dm_we) begin
                idx = dm_addr[7:2];
                case (dm_sz)
                    2'd0: mem[idx] = dm_wd;
                    2'd1: mem[idx][16*dm_addr[1] +: 16] = dm_wd[15:0];
                    default: mem[idx][8*dm_addr[1:0] +: 8] = dm_wd[7:0];
                endcase
            end
        end
        last_w = w;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'(i) * 32'h01010101;
        model_reset();
        last_w = 0;
        rst = 1'b1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h4; cpu_wd = 32'h55; cpu_sz = 0; cpu_ext = 0;
        dma_req = 1; dma_lock = 0; dma_we = 1; dma_addr = 32'h8; dma_wd = 32'h66; dma_sz = 0; dma_ext = 1;

        // reset held with both requesting stores
        #1;
        chk("rst_dm_we", 32'(dm_we), 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        chk("rst_gnt", 32'(dma_gnt), 32'd0);
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("rel_dm_we", 32'(dm_we), 32'd1);
        chk("rel_stall", 32'(cpu_stall), 32'd0);
        cycle();
        cpu_we = 0;
        cycle();
        cpu_req = 0; dma_req = 0;
        cycle();

        // DMA read while CPU idle
        mem[4] = 32'hDEADBEEF;
        dma_req = 1; dma_we = 0; dma_addr = 32'h10; dma_lock = 0;
        #1 chk("dma_read_gnt", 32'(dma_gnt), 32'd1);
        cycle();
        dma_req = 0;
        #1;
        chk("dma_read_valid", 32'(dma_rdv), 32'd1);
        chk("dma_read_data", dma_rd, 32'hDEADBEEF);
        cycle();

        // locked burst: alone grant then MB grants against CPU, then CPU
        dma_req = 1; dma_lock = 1;
        cycle();
        cpu_req = 1; cpu_addr = 32'h20;
        for (int i = 0; i < MB; i++) begin
            #1;
            chk("burst_gnt", 32'(dma_gnt), 32'd1);
            chk("burst_stall", 32'(cpu_stall), 32'd1);
            cycle();
        end
        #1;
        chk("burst_end_gnt", 32'(dma_gnt), 32'd0);
        chk("burst_end_stall", 32'(cpu_stall), 32'd0);
        cycle();
        dma_req = 0; dma_lock = 0; cpu_req = 0;
        cycle();

        // starvation with CPU holding the port
        cpu_req = 1;
        cycle();
        dma_req = 1; dma_lock = 0; dma_we = 0;
        for (int i = 0; i <= SL; i++) begin
            #1;
            chk("starve_gnt", 32'(dma_gnt), 32'(i == SL));
            chk("starve_stall", 32'(cpu_stall), 32'(i == SL));
            cycle();
        end
        dma_req = 0;
        #1 chk("starve_after_stall", 32'(cpu_stall), 32'd0);
        cycle();

        // DMA byte store, then CPU word load of the same word
        cpu_req = 0;
        mem[8] = 32'h11223344;
        dma_req = 1; dma_we = 1; dma_addr = 32'h23; dma_wd = 32'h000000AA; dma_sz = 2;
        cycle();
        dma_req = 0; dma_we = 0; dma_sz = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20; cpu_sz = 0;
        #1 chk("hazard_cpu_rd", cpu_rd, 32'hAA223344);
        cycle();

        // asynchronous reset in the middle of a locked read burst
        cpu_req = 0; dma_req = 1; dma_lock = 1; dma_we = 0; dma_addr = 32'h10;
        cycle();
        cpu_req = 1;
        cycle();
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("arst_gnt", 32'(dma_gnt), 32'd0);
        chk("arst_rdv", 32'(dma_rdv), 32'd0);
        chk("arst_stall", 32'(cpu_stall), 32'd0);
        cycle();
        rst = 1'b0; cpu_req = 0; dma_req = 0;
        #1 chk("arst_no_pulse", 32'(dma_rdv), 32'd0);
        cycle();
        cpu_req = 1; dma_req = 1; dma_lock = 1;
        cycle();
        cpu_req = 0; dma_req = 0; dma_lock = 0;
        cycle();

        // randomized traffic; DMA holds its request and fields until granted
        for (int i = 0; i < 600; i++) begin
            cpu_req = ($urandom_range(0, 3) != 0);
            cpu_we = 1'($urandom_range(0, 1));
            cpu_sz = 2'($urandom_range(0, 2));
            cpu_addr = rand_addr(cpu_sz);
            cpu_wd = $urandom;
            cpu_ext = 1'($urandom_range(0, 1));
            if (dma_req && last_w != 2) begin
                if ($urandom_range(0, 15) == 0) dma_req = 0;
            end else begin
                dma_req = 1'($urandom_range(0, 1));
                dma_lock = ($urandom_range(0, 3) != 0);
                dma_we = 1'($urandom_range(0, 1));
                dma_sz = 2'($urandom_range(0, 2));
                dma_addr = rand_addr(dma_sz);
                dma_wd = $urandom;
                dma_ext = 1'($urandom_range(0, 1));
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
